// File: rtl/axi4_burst_addr_gen_pkg.sv
// ----------------------------------------------------------------------------
// axi4_burst_addr_gen_pkg
//   Shared AXI4 encodings for the burst address sequencer. It holds the burst,
//   size and response types, the sequencer FSM states, and the rule for
//   legal WRAP burst lengths.
//   No ports (package).
// ----------------------------------------------------------------------------
package axi4_burst_addr_gen_pkg;

    typedef enum logic [1:0] {
        BurstFixed = 2'b00,
        BurstIncr  = 2'b01,
        BurstWrap  = 2'b10,
        BurstRsvd  = 2'b11
    } axi_burst_t;

    typedef enum logic [2:0] {
        Size1B   = 3'd0,
        Size2B   = 3'd1,
        Size4B   = 3'd2,
        Size8B   = 3'd3,
        Size16B  = 3'd4,
        Size32B  = 3'd5,
        Size64B  = 3'd6,
        Size128B = 3'd7
    } axi_size_t;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespExokay = 2'b01,
        RespSlverr = 2'b10,
        RespDecerr = 2'b11
    } axi_resp_t;

    typedef enum logic {
        StIdle  = 1'b0,
        StBurst = 1'b1
    } gen_state_e;

    // WRAP bursts must be 2, 4, 8 or 16 beats long.
    function automatic logic axi_wrap_legal(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi4_next_addr.sv
// ----------------------------------------------------------------------------
// axi4_next_addr
//   Combinational next-beat address and current-beat lane strobe for one AXI4
//   burst.
//   i_cur    current beat byte address
//   i_nb     bytes per beat (1 << size), ADDR_WIDTH+1 bits
//   i_lower  WRAP lower boundary, ADDR_WIDTH+1 bits
//   i_wsize  WRAP window size in bytes, ADDR_WIDTH+1 bits
//   i_burst  burst type (axi_burst_t encoding)
//   o_next   address of the following beat (ADDR_WIDTH modulo)
//   o_strb   active byte lanes for i_cur
// ----------------------------------------------------------------------------
module axi4_next_addr
    import axi4_burst_addr_gen_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned NB_MAX     = 4
) (
    input  logic [ADDR_WIDTH-1:0] i_cur,
    input  logic [ADDR_WIDTH:0]   i_nb,
    input  logic [ADDR_WIDTH:0]   i_lower,
    input  logic [ADDR_WIDTH:0]   i_wsize,
    input  logic [1:0]            i_burst,
    output logic [ADDR_WIDTH-1:0] o_next,
    output logic [NB_MAX-1:0]     o_strb
);

    localparam int unsigned AW1 = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] LANE_MASK = AW1'(NB_MAX - 1);

    logic [ADDR_WIDTH:0] w_cur;
    logic [ADDR_WIDTH:0] w_aligned;
    logic [ADDR_WIDTH:0] w_incr;
    logic [ADDR_WIDTH:0] w_next;
    logic [ADDR_WIDTH:0] w_lo;
    logic [ADDR_WIDTH:0] w_hi;

    assign w_cur     = {1'b0, i_cur};
    assign w_aligned = w_cur & ~(i_nb - AW1'(1));
    assign w_incr    = w_aligned + i_nb;

    always_comb begin
        w_next = w_cur;
        unique case (axi_burst_t'(i_burst))
            BurstFixed: w_next = w_cur;
            BurstIncr:  w_next = w_incr;
            // Reaching the top of the window folds back to the lower boundary.
            BurstWrap:  w_next = (w_incr == (i_lower + i_wsize)) ? i_lower : w_incr;
            default:    w_next = w_cur;
        endcase
    end

    assign o_next = w_next[ADDR_WIDTH-1:0];

    // Lanes from the (possibly unaligned) start up to the end of the aligned beat.
    assign w_lo = w_cur & LANE_MASK;
    assign w_hi = (w_aligned & LANE_MASK) + i_nb - AW1'(1);

    always_comb begin
        o_strb = '0;
        for (int unsigned i = 0; i < NB_MAX; i++) begin
            o_strb[i] = (AW1'(i) >= w_lo) && (AW1'(i) <= w_hi);
        end
    end

endmodule

// File: rtl/axi4_burst_addr_gen.sv
// ----------------------------------------------------------------------------
// axi4_burst_addr_gen
//   Per-burst AXI4 address/beat sequencer. Accepts one AW/AR command and then
//   emits one beat per handshake. Each beat carries a byte address, a word
//   index, a lane strobe, a last flag and a response code.
//   i_aclk, i_areset          clock, synchronous active-high reset
//   i_cmd_valid / o_cmd_ready command handshake
//   i_cmd_addr/len/size/burst command fields (AxADDR/AxLEN/AxSIZE/AxBURST)
//   o_beat_valid/i_beat_ready beat handshake
//   o_beat_addr/idx/strb      beat byte address, word index, byte lanes
//   o_beat_last/resp          final-beat flag, per-beat response
// ----------------------------------------------------------------------------
module axi4_burst_addr_gen
    import axi4_burst_addr_gen_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input  logic                         i_aclk,
    input  logic                         i_areset,
    input  logic                         i_cmd_valid,
    output logic                         o_cmd_ready,
    input  logic [ADDR_WIDTH-1:0]        i_cmd_addr,
    input  logic [7:0]                   i_cmd_len,
    input  logic [2:0]                   i_cmd_size,
    input  logic [1:0]                   i_cmd_burst,
    output logic                         o_beat_valid,
    input  logic                         i_beat_ready,
    output logic [ADDR_WIDTH-1:0]        o_beat_addr,
    output logic [$clog2(MEM_DEPTH)-1:0] o_beat_idx,
    output logic [DATA_WIDTH/8-1:0]      o_beat_strb,
    output logic                         o_beat_last,
    output logic [1:0]                   o_beat_resp
);

    localparam int unsigned     NB_MAX      = DATA_WIDTH / 8;
    localparam int unsigned     IDX_W       = $clog2(MEM_DEPTH);
    localparam int unsigned     NB_LOG      = $clog2(NB_MAX);
    localparam int unsigned     BOUNDARY_4K = 4096;
    localparam int unsigned     PAGE_LOG    = $clog2(BOUNDARY_4K);
    localparam int unsigned     AW1         = ADDR_WIDTH + 1;
    localparam longint unsigned MEM_BYTES   = longint'(MEM_DEPTH) * longint'(NB_MAX);

    gen_state_e r_state;
    gen_state_e w_state_d;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_cnt;
    logic [7:0]            r_len;
    logic [ADDR_WIDTH:0]   r_nb;
    logic [ADDR_WIDTH:0]   r_lower;
    logic [ADDR_WIDTH:0]   r_wsize;
    logic [1:0]            r_burst;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_beat_hs;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [NB_MAX-1:0]     w_strb;
    axi_resp_t             w_resp;

    // Command decode, all in ADDR_WIDTH+1 bits so window ends cannot wrap.
    logic [ADDR_WIDTH:0] w_cmd_addr;
    logic [ADDR_WIDTH:0] w_cmd_nb;
    logic [ADDR_WIDTH:0] w_cmd_beats;
    logic [ADDR_WIDTH:0] w_cmd_wsize;
    logic [ADDR_WIDTH:0] w_cmd_lower;
    logic [ADDR_WIDTH:0] w_cmd_aligned;
    logic [ADDR_WIDTH:0] w_cmd_end;
    logic                w_cmd_cross;
    logic                w_cmd_err;

    assign w_cmd_addr    = {1'b0, i_cmd_addr};
    assign w_cmd_nb      = AW1'(1) << i_cmd_size;
    assign w_cmd_beats   = AW1'(i_cmd_len) + AW1'(1);
    assign w_cmd_wsize   = w_cmd_nb * w_cmd_beats;
    assign w_cmd_lower   = w_cmd_addr & ~(w_cmd_wsize - AW1'(1));
    assign w_cmd_aligned = w_cmd_addr & ~(w_cmd_nb - AW1'(1));
    assign w_cmd_end     = w_cmd_aligned + w_cmd_wsize - AW1'(1);
    assign w_cmd_cross   = (w_cmd_aligned >> PAGE_LOG) != (w_cmd_end >> PAGE_LOG);

    // Burst-level error, latched at accept and applied to every beat.
    always_comb begin
        w_cmd_err = 1'b0;
        if (i_cmd_burst == BurstRsvd) begin
            w_cmd_err = 1'b1;
        end else if (w_cmd_nb > AW1'(NB_MAX)) begin
            w_cmd_err = 1'b1;
        end else if ((i_cmd_burst == BurstWrap) && !axi_wrap_legal(i_cmd_len)) begin
            w_cmd_err = 1'b1;
        end else if ((i_cmd_burst == BurstWrap) &&
                     ((w_cmd_addr & (w_cmd_nb - AW1'(1))) != '0)) begin
            w_cmd_err = 1'b1;
        end else if ((i_cmd_burst == BurstIncr) && w_cmd_cross) begin
            w_cmd_err = 1'b1;
        end
    end

    assign w_accept  = (r_state == StIdle) && i_cmd_valid;
    assign w_beat_hs = (r_state == StBurst) && i_beat_ready;
    assign w_last    = (r_state == StBurst) && (r_cnt == r_len);

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (i_cmd_valid) w_state_d = StBurst;
            StBurst: if (w_beat_hs && w_last) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_nb    <= '0;
            r_lower <= '0;
            r_wsize <= '0;
            r_burst <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_addr  <= i_cmd_addr;
                r_cnt   <= '0;
                r_len   <= i_cmd_len;
                r_nb    <= w_cmd_nb;
                r_lower <= w_cmd_lower;
                r_wsize <= w_cmd_wsize;
                r_burst <= i_cmd_burst;
                r_err   <= w_cmd_err;
            end else if (w_beat_hs && !w_last) begin
                r_addr <= w_next_addr;
                r_cnt  <= r_cnt + 8'd1;
            end
        end
    end

    axi4_next_addr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NB_MAX     (NB_MAX)
    ) u_next_addr (
        .i_cur   (r_addr),
        .i_nb    (r_nb),
        .i_lower (r_lower),
        .i_wsize (r_wsize),
        .i_burst (r_burst),
        .o_next  (w_next_addr),
        .o_strb  (w_strb)
    );

    always_comb begin
        w_resp = RespOkay;
        if (r_state == StBurst) begin
            if (r_err) begin
                w_resp = RespSlverr;
            end else if (64'(r_addr) >= MEM_BYTES) begin
                w_resp = RespDecerr;
            end
        end
    end

    // Beat outputs read zero outside a burst; error beats carry no lanes or index.
    assign o_cmd_ready  = (r_state == StIdle);
    assign o_beat_valid = (r_state == StBurst);
    assign o_beat_addr  = (r_state == StBurst) ? r_addr : '0;
    assign o_beat_last  = w_last;
    assign o_beat_resp  = w_resp;
    assign o_beat_strb  = ((r_state == StBurst) && (w_resp == RespOkay)) ? w_strb : '0;
    assign o_beat_idx   = ((r_state == StBurst) && (w_resp == RespOkay)) ?
                          IDX_W'(r_addr >> NB_LOG) : '0;

endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
module tb_axi4_burst_addr_gen;

    logic        clk = 1'b0;
    logic        i_areset;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [15:0] i_cmd_addr;
    logic [7:0]  i_cmd_len;
    logic [2:0]  i_cmd_size;
    logic [1:0]  i_cmd_burst;
    logic        o_beat_valid;
    logic        i_beat_ready;
    logic [15:0] o_beat_addr;
    logic [9:0]  o_beat_idx;
    logic [3:0]  o_beat_strb;
    logic        o_beat_last;
    logic [1:0]  o_beat_resp;

    always #5 clk = ~clk;

    axi4_burst_addr_gen #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (1024)
    ) dut (
        .i_aclk       (clk),
        .i_areset     (i_areset),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_addr   (i_cmd_addr),
        .i_cmd_len    (i_cmd_len),
        .i_cmd_size   (i_cmd_size),
        .i_cmd_burst  (i_cmd_burst),
        .o_beat_valid (o_beat_valid),
        .i_beat_ready (i_beat_ready),
        .o_beat_addr  (o_beat_addr),
        .o_beat_idx   (o_beat_idx),
        .o_beat_strb  (o_beat_strb),
        .o_beat_last  (o_beat_last),
        .o_beat_resp  (o_beat_resp)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [9:0]  idx;
        logic [3:0]  strb;
        logic        last;
        logic [1:0]  resp;
    } beat_t;

    typedef struct packed {
        logic [15:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [3:0][15:0] e_addr;
        logic [3:0][3:0]  e_strb;
        logic [1:0]       e_resp;
    } vec_t;

    beat_t q[$];
    vec_t  vecs[12];
    int    n_checks = 0;
    int    n_pass   = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endfunction

    function automatic vec_t mk(input logic [15:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst,
                                input logic [15:0] a0, input logic [15:0] a1,
                                input logic [15:0] a2, input logic [15:0] a3,
                                input logic [3:0] s0, input logic [3:0] s1,
                                input logic [3:0] s2, input logic [3:0] s3,
                                input logic [1:0] resp);
        vec_t v;
        v.addr = addr; v.len = len; v.size = size; v.burst = burst;
        v.e_addr[0] = a0; v.e_addr[1] = a1; v.e_addr[2] = a2; v.e_addr[3] = a3;
        v.e_strb[0] = s0; v.e_strb[1] = s1; v.e_strb[2] = s2; v.e_strb[3] = s3;
        v.e_resp = resp;
        return v;
    endfunction

    // Scoreboard consumer: compare on every beat handshake.
    always @(negedge clk) begin : mon
        beat_t e;
        if (o_beat_valid && i_beat_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_beat: got addr 0x%0h, expected no beat", o_beat_addr);
            end else begin
                e = q.pop_front();
                chk("beat_addr", 32'(o_beat_addr), 32'(e.addr));
                chk("beat_idx",  32'(o_beat_idx),  32'(e.idx));
                chk("beat_strb", 32'(o_beat_strb), 32'(e.strb));
                chk("beat_last", 32'(o_beat_last), 32'(e.last));
                chk("beat_resp", 32'(o_beat_resp), 32'(e.resp));
            end
        end
    end

    task automatic send_cmd(input vec_t v);
        beat_t       e;
        logic [15:0] a;
        bit          got;
        i_cmd_addr  = v.addr;
        i_cmd_len   = v.len;
        i_cmd_size  = v.size;
        i_cmd_burst = v.burst;
        i_cmd_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_cmd_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            $display("FAIL cmd_accept: got cmd_ready 0 for 20 cycles, expected 1");
            i_cmd_valid = 1'b0;
            return;
        end
        for (int b = 0; b <= int'(v.len); b++) begin
            a      = v.e_addr[b];
            e.addr = a;
            e.strb = v.e_strb[b];
            e.resp = v.e_resp;
            e.idx  = (v.e_resp == 2'd0) ? a[11:2] : 10'd0;
            e.last = (b == int'(v.len));
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        i_cmd_valid = 1'b0;
        chk("first_beat_valid", 32'(o_beat_valid), 32'd1);
        chk("cmd_ready_busy",   32'(o_cmd_ready),  32'd0);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL burst_done: got %0d beats outstanding, expected 0", q.size());
            q.delete();
        end else begin
            chk("idle_valid_after_last", 32'(o_beat_valid), 32'd0);
            chk("cmd_ready_after_last",  32'(o_cmd_ready),  32'd1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(16'h0010, 8'd3, 3'd2, 2'd1, 16'h0010, 16'h0014, 16'h0018, 16'h001C,
                      4'hF, 4'hF, 4'hF, 4'hF, 2'd0);
        vecs[1]  = mk(16'h0011, 8'd1, 3'd2, 2'd1, 16'h0011, 16'h0014, 16'h0, 16'h0,
                      4'hE, 4'hF, 4'h0, 4'h0, 2'd0);
        vecs[2]  = mk(16'h0008, 8'd2, 3'd1, 2'd0, 16'h0008, 16'h0008, 16'h0008, 16'h0,
                      4'h3, 4'h3, 4'h3, 4'h0, 2'd0);
        vecs[3]  = mk(16'h0034, 8'd3, 3'd2, 2'd2, 16'h0034, 16'h0038, 16'h003C, 16'h0030,
                      4'hF, 4'hF, 4'hF, 4'hF, 2'd0);
        vecs[4]  = mk(16'h0034, 8'd2, 3'd2, 2'd2, 16'h0034, 16'h0038, 16'h003C, 16'h0,
                      4'h0, 4'h0, 4'h0, 4'h0, 2'd2);
        vecs[5]  = mk(16'h0FF8, 8'd3, 3'd2, 2'd1, 16'h0FF8, 16'h0FFC, 16'h1000, 16'h1004,
                      4'h0, 4'h0, 4'h0, 4'h0, 2'd2);
        vecs[6]  = mk(16'h0020, 8'd0, 3'd2, 2'd3, 16'h0020, 16'h0, 16'h0, 16'h0,
                      4'h0, 4'h0, 4'h0, 4'h0, 2'd2);
        vecs[7]  = mk(16'h0040, 8'd0, 3'd3, 2'd1, 16'h0040, 16'h0, 16'h0, 16'h0,
                      4'h0, 4'h0, 4'h0, 4'h0, 2'd2);
        vecs[8]  = mk(16'h1000, 8'd0, 3'd2, 2'd1, 16'h1000, 16'h0, 16'h0, 16'h0,
                      4'h0, 4'h0, 4'h0, 4'h0, 2'd3);
        vecs[9]  = mk(16'h0FFC, 8'd0, 3'd2, 2'd1, 16'h0FFC, 16'h0, 16'h0, 16'h0,
                      4'hF, 4'h0, 4'h0, 4'h0, 2'd0);
        vecs[10] = mk(16'h0001, 8'd2, 3'd0, 2'd1, 16'h0001, 16'h0002, 16'h0003, 16'h0,
                      4'h2, 4'h4, 4'h8, 4'h0, 2'd0);
        vecs[11] = mk(16'h1000, 8'd1, 3'd2, 2'd0, 16'h1000, 16'h1000, 16'h0, 16'h0,
                      4'h0, 4'h0, 4'h0, 4'h0, 2'd3);

        i_areset     = 1'b1;
        i_cmd_valid  = 1'b0;
        i_cmd_addr   = '0;
        i_cmd_len    = '0;
        i_cmd_size   = '0;
        i_cmd_burst  = '0;
        i_beat_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        i_areset = 1'b0;
        chk("rst_cmd_ready",  32'(o_cmd_ready),  32'd1);
        chk("rst_beat_valid", 32'(o_beat_valid), 32'd0);
        chk("rst_beat_addr",  32'(o_beat_addr),  32'd0);
        chk("rst_beat_idx",   32'(o_beat_idx),   32'd0);
        chk("rst_beat_strb",  32'(o_beat_strb),  32'd0);
        chk("rst_beat_last",  32'(o_beat_last),  32'd0);
        chk("rst_beat_resp",  32'(o_beat_resp),  32'd0);

        for (int i = 0; i < 12; i++) begin
            send_cmd(vecs[i]);
            wait_done();
        end

        // Stall on the third beat for three cycles.
        send_cmd(mk(16'h0100, 8'd3, 3'd2, 2'd1, 16'h0100, 16'h0104, 16'h0108, 16'h010C,
                    4'hF, 4'hF, 4'hF, 4'hF, 2'd0));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        i_beat_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", 32'(o_beat_valid), 32'd1);
            chk("stall_addr",  32'(o_beat_addr),  32'h0108);
            chk("stall_strb",  32'(o_beat_strb),  32'hF);
            chk("stall_last",  32'(o_beat_last),  32'd0);
        end
        i_beat_ready = 1'b1;
        wait_done();

        // Reset while the fourth beat is presented.
        send_cmd(mk(16'h0200, 8'd3, 3'd2, 2'd1, 16'h0200, 16'h0204, 16'h0208, 16'h020C,
                    4'hF, 4'hF, 4'hF, 4'hF, 2'd0));
        repeat (3) @(posedge clk);
        #1;
        i_beat_ready = 1'b0;
        chk("pre_reset_addr", 32'(o_beat_addr), 32'h020C);
        i_areset = 1'b1;
        @(posedge clk);
        #1;
        i_areset = 1'b0;
        chk("mid_rst_valid",     32'(o_beat_valid), 32'd0);
        chk("mid_rst_cmd_ready", 32'(o_cmd_ready),  32'd1);
        chk("mid_rst_addr",      32'(o_beat_addr),  32'd0);
        chk("mid_rst_last",      32'(o_beat_last),  32'd0);
        chk("mid_rst_beats_left", 32'(q.size()),    32'd1);
        q.delete();
        i_beat_ready = 1'b1;

        send_cmd(vecs[0]);
        wait_done();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
